// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the core memory stage (master) and the load/store unit (slave).
// A transfer happens on a clock edge where valid && ready; the valid side holds its payload stable until then.
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit for the 64 KiB dual-port DMEM: byte requests become word index + byte enables,
// word-crossing accesses split across port A (word w) and port B (word w+1) in one cycle.
module dmem_lsu #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    dmem_lsu_if.slave   lsu,
    output logic [13:0] o_address_a,
    output logic [31:0] o_data_a,
    output logic [3:0]  o_wren_a,
    input  logic [31:0] i_q_a,
    output logic [13:0] o_address_b,
    output logic [31:0] o_data_b,
    output logic [3:0]  o_wren_b,
    input  logic [31:0] i_q_b,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  state;
    logic        r_we;
    logic        r_unsigned;
    logic        r_err;
    logic [1:0]  r_size;
    logic [1:0]  r_ofs;
    logic [13:0] address_a_q;
    logic [13:0] address_b_q;
    logic [31:0] data_a_q;
    logic [31:0] data_b_q;
    logic [3:0]  wren_a_q;
    logic [3:0]  wren_b_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    // Request decode, evaluated on the incoming request in IDLE
    logic [31:0] off;
    logic [1:0]  ofs;
    logic [13:0] word;
    logic [2:0]  nbytes;
    logic [3:0]  mask4;
    logic [3:0]  last;
    logic        dec_err;
    logic [7:0]  mask8;
    logic [63:0] wdata64;

    always_comb begin
        off     = lsu.req_addr - BASE_ADDR;
        ofs     = off[1:0];
        word    = off[15:2];
        nbytes  = 3'd0;
        mask4   = 4'b0000;
        case (lsu.req_size)
            2'd0: begin nbytes = 3'd1; mask4 = 4'b0001; end
            2'd1: begin nbytes = 3'd2; mask4 = 4'b0011; end
            2'd2: begin nbytes = 3'd4; mask4 = 4'b1111; end
            default: begin nbytes = 3'd0; mask4 = 4'b0000; end
        endcase
        last    = {2'b00, ofs} + {1'b0, nbytes};
        dec_err = (off[31:16] != 16'd0) || (lsu.req_size == 2'd3) ||
                  ((word == 14'h3FFF) && (last > 4'd4));
        mask8   = {4'b0000, mask4} << ofs;
        wdata64 = {32'd0, lsu.req_wdata} << {ofs, 3'b000};
    end

    // Load alignment from the two registered DMEM read words
    logic [63:0] raw64;
    logic [31:0] raw;
    logic [31:0] load_data;
    logic        unused_raw_hi;

    always_comb begin
        raw64     = {i_q_b, i_q_a} >> {r_ofs, 3'b000};
        raw       = raw64[31:0];
        load_data = 32'd0;
        case (r_size)
            2'd0: load_data = r_unsigned ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1: load_data = r_unsigned ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            2'd2: load_data = raw;
            default: load_data = 32'd0;
        endcase
        if (r_we || r_err) begin
            load_data = 32'd0;
        end
    end

    assign unused_raw_hi = ^raw64[63:32];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            r_we        <= 1'b0;
            r_unsigned  <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= 2'd0;
            r_ofs       <= 2'd0;
            address_a_q <= 14'd0;
            address_b_q <= 14'd0;
            data_a_q    <= 32'd0;
            data_b_q    <= 32'd0;
            wren_a_q    <= 4'b0000;
            wren_b_q    <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (lsu.req_valid) begin
                        r_we        <= lsu.req_we;
                        r_unsigned  <= lsu.req_unsigned;
                        r_err       <= dec_err;
                        r_size      <= lsu.req_size;
                        r_ofs       <= ofs;
                        address_a_q <= word;
                        address_b_q <= word + 14'd1;
                        data_a_q    <= wdata64[31:0];
                        data_b_q    <= wdata64[63:32];
                        wren_a_q    <= (lsu.req_we && !dec_err) ? mask8[3:0] : 4'b0000;
                        wren_b_q    <= (lsu.req_we && !dec_err) ? mask8[7:4] : 4'b0000;
                        state       <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Addresses stay put so the read words remain valid through RESP
                    wren_a_q <= 4'b0000;
                    wren_b_q <= 4'b0000;
                    state    <= S_RESP;
                end
                S_RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= r_err;
                        rsp_rdata_q <= load_data;
                    end else if (lsu.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign lsu.req_ready = (state == S_IDLE);
    assign lsu.rsp_valid = rsp_valid_q;
    assign lsu.rsp_err   = rsp_err_q;
    assign lsu.rsp_rdata = rsp_rdata_q;

    assign o_address_a = address_a_q;
    assign o_address_b = address_b_q;
    assign o_data_a    = data_a_q;
    assign o_data_b    = data_b_q;
    // Gate enables with reset so a store interrupted by reset never reaches memory
    assign o_wren_a    = i_reset ? wren_a_q : 4'b0000;
    assign o_wren_b    = i_reset ? wren_b_q : 4'b0000;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: dual-port RAM stand-in, byte-level reference memory, directed and random scenarios.
module tb_dmem_lsu;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [13:0] address_a, address_b;
    logic [31:0] data_a, data_b, q_a, q_b;
    logic [3:0]  wren_a, wren_b;
    logic [1:0]  dbg_state;
    logic        ram_clear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    dmem_lsu_if bus ();

    dmem_lsu #(.BASE_ADDR(BASE)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .lsu         (bus),
        .o_address_a (address_a),
        .o_data_a    (data_a),
        .o_wren_a    (wren_a),
        .i_q_a       (q_a),
        .o_address_b (address_b),
        .o_data_b    (data_b),
        .o_wren_b    (wren_b),
        .i_q_b       (q_b),
        .o_dbg_state (dbg_state)
    );

    // Dual-port synchronous RAM, read-before-write, registered outputs
    logic [31:0] ram [0:16383];
    always @(posedge i_clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 16384; i++) ram[i] <= 32'd0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (wren_a[l]) ram[address_a][8*l +: 8] <= data_a[8*l +: 8];
                if (wren_b[l]) ram[address_b][8*l +: 8] <= data_b[8*l +: 8];
            end
        end
        q_a <= ram[address_a];
        q_b <= ram[address_b];
    end

    // Reference: the 64 KiB window as a flat byte array
    logic [7:0] ref_mem [0:65535];

    function automatic int model_nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [31:0] addr, input logic [1:0] sz);
        logic [32:0] off;
        off = {1'b0, addr - BASE};
        return (sz == 2'd3) || (off + 33'(model_nbytes(sz)) > 33'h1_0000);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
        logic [31:0] off, v;
        int n;
        off = addr - BASE;
        n = model_nbytes(sz);
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[off[15:0] + 16'(k)];
        if (!uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] off;
        off = addr - BASE;
        for (int k = 0; k < model_nbytes(sz); k++) ref_mem[off[15:0] + 16'(k)] = wd[8*k +: 8];
    endfunction

    function automatic void model_wren(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                                       output logic [3:0] wa, output logic [3:0] wb);
        logic [31:0] off;
        logic [15:0] pos;
        wa = 4'b0000;
        wb = 4'b0000;
        off = addr - BASE;
        if (we && !model_err(addr, sz)) begin
            for (int k = 0; k < model_nbytes(sz); k++) begin
                pos = off[15:0] + 16'(k);
                if (pos[15:2] == off[15:2]) wa[pos[1:0]] = 1'b1;
                else wb[pos[1:0]] = 1'b1;
            end
        end
    endfunction

    // Observations of the last transaction
    logic        obs_ready, obs_timeout, obs_err;
    logic [1:0]  obs_acc_state;
    logic [3:0]  obs_wren_a, obs_wren_b;
    logic [13:0] obs_addr_a, obs_addr_b;
    logic [31:0] obs_rdata;
    int          obs_lat;

    // Called at a negedge with the LSU idle; returns at a negedge with the LSU idle again
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input int hold);
        obs_ready = bus.req_ready;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req_valid = 1'b0;
        obs_acc_state = dbg_state;
        obs_wren_a    = wren_a;
        obs_wren_b    = wren_b;
        obs_addr_a    = address_a;
        obs_addr_b    = address_b;
        obs_lat       = 0;
        obs_timeout   = 1'b1;
        for (int c = 1; c <= 20 && obs_timeout; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (bus.rsp_valid) begin
                obs_timeout = 1'b0;
                obs_lat = c;
            end
        end
        repeat (hold) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        obs_rdata = bus.rsp_rdata;
        obs_err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        i_reset = 1'b0;
        ram_clear = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'd0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
        n_cmp++; if (bus.rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
        n_cmp++; if ({address_a, address_b} !== 28'd0) begin n_bad++; $display("FAIL reset_address got %h/%h want 0/0", address_a, address_b); end
        n_cmp++; if ({data_a, data_b} !== 64'd0) begin n_bad++; $display("FAIL reset_data got %h/%h want 0/0", data_a, data_b); end
        n_cmp++; if ({wren_a, wren_b} !== 8'd0) begin n_bad++; $display("FAIL reset_wren got %b/%b want 0/0", wren_a, wren_b); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        ram_clear = 1'b0;
        i_reset = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_directed;
        run_req(1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'hDEAD_BEEF, 0);
        model_store(BASE + 32'h8, 2'd2, 32'hDEAD_BEEF);
        n_cmp++; if (obs_wren_a !== 4'b1111 || obs_wren_b !== 4'b0000) begin n_bad++; $display("FAIL sw_wren got %b/%b want 1111/0000", obs_wren_a, obs_wren_b); end
        n_cmp++; if (obs_err !== 1'b0 || obs_rdata !== 32'd0) begin n_bad++; $display("FAIL sw_rsp got err=%b rdata=%h want 0/0", obs_err, obs_rdata); end
        run_req(1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'd0, 0);
        n_cmp++; if (obs_timeout !== 1'b0 || obs_lat != 2) begin n_bad++; $display("FAIL lw_latency got %0d want 2", obs_lat); end
        n_cmp++; if (obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin n_bad++; $display("FAIL lw_rdata got %h err=%b want deadbeef err=0", obs_rdata, obs_err); end

        run_req(1'b1, 2'd0, 1'b0, BASE + 32'h9, 32'h80, 0);
        model_store(BASE + 32'h9, 2'd0, 32'h80);
        n_cmp++; if (obs_wren_a !== 4'b0010 || obs_wren_b !== 4'b0000) begin n_bad++; $display("FAIL sb_wren got %b/%b want 0010/0000", obs_wren_a, obs_wren_b); end
        run_req(1'b0, 2'd0, 1'b0, BASE + 32'h9, 32'd0, 0);
        n_cmp++; if (obs_rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_sext got %h want ffffff80", obs_rdata); end
        run_req(1'b0, 2'd0, 1'b1, BASE + 32'h9, 32'd0, 0);
        n_cmp++; if (obs_rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_zext got %h want 00000080", obs_rdata); end

        run_req(1'b1, 2'd2, 1'b0, BASE + 32'h6, 32'h1122_3344, 0);
        model_store(BASE + 32'h6, 2'd2, 32'h1122_3344);
        n_cmp++; if (obs_wren_a !== 4'b1100 || obs_wren_b !== 4'b0011) begin n_bad++; $display("FAIL sw_split_wren got %b/%b want 1100/0011", obs_wren_a, obs_wren_b); end
        n_cmp++; if (obs_addr_a !== 14'd1 || obs_addr_b !== 14'd2) begin n_bad++; $display("FAIL sw_split_addr got %0d/%0d want 1/2", obs_addr_a, obs_addr_b); end
        run_req(1'b0, 2'd2, 1'b0, BASE + 32'h6, 32'd0, 0);
        n_cmp++; if (obs_rdata !== 32'h1122_3344) begin n_bad++; $display("FAIL lw_split got %h want 11223344", obs_rdata); end
        run_req(1'b0, 2'd1, 1'b0, BASE + 32'h7, 32'd0, 0);
        n_cmp++; if (obs_rdata !== 32'h0000_2233) begin n_bad++; $display("FAIL lh_split got %h want 00002233", obs_rdata); end
    endtask

    task automatic test_errors;
        logic        we_t [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  sz_t [6]  = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1};
        logic [31:0] ad_t [6]  = '{BASE + 32'hFFFE, BASE + 32'h1_0000, BASE, BASE + 32'h4, BASE - 32'd1, BASE + 32'hFFFF};
        for (int i = 0; i < 6; i++) begin
            run_req(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'hA5A5_5A5A, 0);
            n_cmp++; if (obs_err !== 1'b1 || obs_rdata !== 32'd0) begin n_bad++; $display("FAIL err_case%0d got err=%b rdata=%h want 1/0", i, obs_err, obs_rdata); end
            n_cmp++; if (obs_wren_a !== 4'b0000 || obs_wren_b !== 4'b0000) begin n_bad++; $display("FAIL err_wren%0d got %b/%b want 0000/0000", i, obs_wren_a, obs_wren_b); end
        end
        // A rejected store at BASE+0x10000 aliases word 0; it must not have landed
        run_req(1'b0, 2'd2, 1'b0, BASE, 32'd0, 0);
        n_cmp++; if (obs_rdata !== model_load(BASE, 2'd2, 1'b0)) begin n_bad++; $display("FAIL err_no_write got %h want %h", obs_rdata, model_load(BASE, 2'd2, 1'b0)); end
        run_req(1'b1, 2'd0, 1'b0, BASE + 32'hFFFF, 32'h7E, 0);
        model_store(BASE + 32'hFFFF, 2'd0, 32'h7E);
        n_cmp++; if (obs_err !== 1'b0 || obs_wren_a !== 4'b1000 || obs_addr_a !== 14'h3FFF) begin n_bad++; $display("FAIL top_byte got err=%b wren=%b addr=%h want 0/1000/3fff", obs_err, obs_wren_a, obs_addr_a); end
        run_req(1'b0, 2'd2, 1'b0, BASE + 32'hFFFC, 32'd0, 0);
        n_cmp++; if (obs_err !== 1'b0 || obs_rdata !== model_load(BASE + 32'hFFFC, 2'd2, 1'b0)) begin n_bad++; $display("FAIL top_word got err=%b rdata=%h", obs_err, obs_rdata); end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        logic        seen;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = BASE + 32'h8;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            seen = bus.rsp_valid;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL bp_rsp_timeout got 0 want 1"); end
        held = bus.rsp_rdata;
        n_cmp++; if (held !== model_load(BASE + 32'h8, 2'd2, 1'b0)) begin n_bad++; $display("FAIL bp_rdata got %h want %h", held, model_load(BASE + 32'h8, 2'd2, 1'b0)); end
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== held || bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b want 1/%h/0", c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, held); end
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b1; bus.req_addr = BASE + 32'h9;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.rsp_ready = 1'b0;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL bp_release got v=%b rdy=%b st=%0d want 0/1/0", bus.rsp_valid, bus.req_ready, dbg_state); end
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req_valid = 1'b0;
        n_cmp++; if (dbg_state !== 2'd1 || bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_next_accept got st=%0d rdy=%b want 1/0", dbg_state, bus.req_ready); end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            seen = bus.rsp_valid;
        end
        n_cmp++; if (seen !== 1'b1 || bus.rsp_rdata !== model_load(BASE + 32'h9, 2'd0, 1'b1)) begin n_bad++; $display("FAIL bp_next_rdata got %h want %h", bus.rsp_rdata, model_load(BASE + 32'h9, 2'd0, 1'b1)); end
        bus.rsp_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = BASE + 32'h40;
        bus.req_wdata = 32'hCAFE_F00D;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.req_valid = 1'b0;
        n_cmp++; if (dbg_state !== 2'd1) begin n_bad++; $display("FAIL rm_in_access got %0d want 1", dbg_state); end
        i_reset = 1'b0;
        #1;
        n_cmp++; if (wren_a !== 4'b0000 || wren_b !== 4'b0000) begin n_bad++; $display("FAIL rm_wren_gated got %b/%b want 0000/0000", wren_a, wren_b); end
        @(posedge i_clk);
        @(negedge i_clk);
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin n_bad++; $display("FAIL rm_after got rdy=%b v=%b st=%0d want 1/0/0", bus.req_ready, bus.rsp_valid, dbg_state); end
        i_reset = 1'b1;
        @(negedge i_clk);
        run_req(1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'd0, 0);
        n_cmp++; if (obs_rdata !== model_load(BASE + 32'h40, 2'd2, 1'b0)) begin n_bad++; $display("FAIL rm_no_write got %h want %h", obs_rdata, model_load(BASE + 32'h40, 2'd2, 1'b0)); end
    endtask

    task automatic test_random;
        logic [31:0] off, addr, wd, exp_d;
        logic [1:0]  sz;
        logic        we, uns, exp_e;
        logic [3:0]  exp_wa, exp_wb;
        int          sel;
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       off = 32'($urandom_range(0, 63));
            else if (sel < 8)  off = 32'hFFF0 + 32'($urandom_range(0, 15));
            else if (sel == 8) off = 32'h1_0000 + 32'($urandom_range(0, 255));
            else               off = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            addr = BASE + off;
            sz   = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            exp_e = model_err(addr, sz);
            exp_d = (we || exp_e) ? 32'd0 : model_load(addr, sz, uns);
            model_wren(we, sz, addr, exp_wa, exp_wb);
            run_req(we, sz, uns, addr, wd, $urandom_range(0, 3));
            n_cmp++; if (obs_ready !== 1'b1 || obs_timeout !== 1'b0 || obs_lat != 2) begin n_bad++; $display("FAIL rnd%0d_timing rdy=%b lat=%0d want 1/2", i, obs_ready, obs_lat); end
            n_cmp++; if (obs_err !== exp_e) begin n_bad++; $display("FAIL rnd%0d_err addr=%h sz=%0d got %b want %b", i, addr, sz, obs_err, exp_e); end
            n_cmp++; if (obs_rdata !== exp_d) begin n_bad++; $display("FAIL rnd%0d_rdata addr=%h sz=%0d got %h want %h", i, addr, sz, obs_rdata, exp_d); end
            n_cmp++; if (obs_wren_a !== exp_wa || obs_wren_b !== exp_wb) begin n_bad++; $display("FAIL rnd%0d_wren got %b/%b want %b/%b", i, obs_wren_a, obs_wren_b, exp_wa, exp_wb); end
            if (!exp_e) begin
                n_cmp++; if (obs_addr_a !== off[15:2] || obs_addr_b !== off[15:2] + 14'd1) begin n_bad++; $display("FAIL rnd%0d_addr got %h/%h want %h/%h", i, obs_addr_a, obs_addr_b, off[15:2], off[15:2] + 14'd1); end
            end
            if (we && !exp_e) model_store(addr, sz, wd);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
